// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: request/result handshake bundle for the sequential multiplier
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               zero_flag;
    logic               busy;
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, product, zero_flag, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, product, zero_flag, busy
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shift-and-add unsigned multiplier sequencer reusing one adder
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_1,
    input  logic [WIDTH-1:0] i_2,
    input  logic             invert_i_2,
    input  logic             enable,
    output logic [WIDTH-1:0] sum,
    output logic             overflow_flag
);
    logic [WIDTH:0] r;
    assign r = enable ? {1'b0, i_1} + {1'b0, invert_i_2 ? ~i_2 : i_2} + (WIDTH+1)'(invert_i_2) : '0;
    assign sum = r[WIDTH-1:0];
    assign overflow_flag = r[WIDTH];
endmodule

module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    input logic           clear,
    mul_seq_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state, nxt;
    logic [WIDTH-1:0] mcand, acc, mq, sum;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             last;
    assign last = cnt == CNT_W'(WIDTH - 1);
    adder #(.WIDTH(WIDTH)) u_add (
        .i_1(acc),
        .i_2(mq[0] ? mcand : '0),
        .invert_i_2(1'b0),
        .enable(1'b1),
        .sum(sum),
        .overflow_flag(c)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    // next state: clear wins, then accept / finish / hand off
    always_comb begin
        nxt = state;
        if (clear)                              nxt = IDLE;
        else if (state == IDLE && bus.in_valid) nxt = BUSY;
        else if (state == BUSY && last)         nxt = DONE;
        else if (state == DONE && bus.out_ready) nxt = IDLE;
    end
    // datapath: load operands on accept, one partial product per BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            mq    <= '0;
            cnt   <= '0;
        end else if (clear) begin
            acc <= '0;
            mq  <= '0;
            cnt <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            mcand <= bus.in_a;
            mq    <= bus.in_b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == BUSY) begin
            {acc, mq} <= {c, sum, mq[WIDTH-1:1]};
            cnt       <= cnt + CNT_W'(1);
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.product   = {acc, mq};
    assign bus.zero_flag = ~|{acc, mq};
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed checks at WIDTH=8 plus randomized products at WIDTH=32
module tb_mul_seq_ctrl;
    logic clk = 0;
    logic rst = 1;
    logic clear = 0;
    int   passed = 0;
    int   total = 0;
    always #5 clk = ~clk;
    mul_seq_ctrl_if #(.WIDTH(8))  b8 ();
    mul_seq_ctrl_if #(.WIDTH(32)) b32 ();
    mul_seq_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .clear(clear), .bus(b8.slave));
    mul_seq_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .clear(clear), .bus(b32.slave));
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        b8.in_a = a;
        b8.in_b = b;
        b8.in_valid = 1;
        tick();
        b8.in_valid = 0;
        b8.in_a = ~a;
        b8.in_b = ~b;
    endtask
    initial begin
        logic [31:0] a, b;
        logic [63:0] e;
        bit          got;
        b8.in_valid = 0; b8.in_a = 0; b8.in_b = 0; b8.out_ready = 0;
        b32.in_valid = 0; b32.in_a = 0; b32.in_b = 0; b32.out_ready = 0;
        #12;
        chk("rst_out_valid", 64'(b8.out_valid), 0);
        chk("rst_busy", 64'(b8.busy), 0);
        chk("rst_product", 64'(b8.product), 0);
        chk("rst_zero", 64'(b8.zero_flag), 1);
        rst = 0;
        tick();
        chk("rst_in_ready", 64'(b8.in_ready), 1);
        // 0xFF * 0xFF with held output
        start8(8'hFF, 8'hFF);
        chk("ff_busy", 64'(b8.busy), 1);
        chk("ff_in_ready", 64'(b8.in_ready), 0);
        tick(7);
        chk("ff_not_yet", 64'(b8.out_valid), 0);
        tick();
        chk("ff_valid", 64'(b8.out_valid), 1);
        chk("ff_product", 64'(b8.product), 64'hFE01);
        chk("ff_zero", 64'(b8.zero_flag), 0);
        tick(3);
        chk("ff_held", 64'(b8.product), 64'hFE01);
        chk("ff_valid_held", 64'(b8.out_valid), 1);
        b8.out_ready = 1;
        tick();
        b8.out_ready = 0;
        chk("ff_drop", 64'(b8.out_valid), 0);
        chk("ff_idle", 64'(b8.in_ready), 1);
        // zero operand still takes full latency
        start8(8'h00, 8'hA5);
        tick(7);
        chk("z_not_yet", 64'(b8.out_valid), 0);
        tick();
        chk("z_valid", 64'(b8.out_valid), 1);
        chk("z_product", 64'(b8.product), 0);
        chk("z_zero", 64'(b8.zero_flag), 1);
        b8.out_ready = 1;
        tick();
        b8.out_ready = 0;
        chk("z_idle", 64'(b8.in_ready), 1);
        // long backpressure, in_ready stays low in DONE
        start8(8'h0D, 8'h0B);
        tick(8);
        for (int i = 0; i < 20; i++) begin
            chk("bp_product", 64'(b8.product), 64'h008F);
            tick();
        end
        chk("bp_valid", 64'(b8.out_valid), 1);
        b8.out_ready = 1;
        b8.in_valid = 1;
        chk("bp_no_ready_in_done", 64'(b8.in_ready), 0);
        tick();
        b8.out_ready = 0;
        b8.in_valid = 0;
        chk("bp_drop", 64'(b8.out_valid), 0);
        chk("bp_in_ready", 64'(b8.in_ready), 1);
        tick();
        chk("bp_not_accepted", 64'(b8.busy), 0);
        // clear on 4th BUSY cycle
        start8(8'h77, 8'h99);
        tick(3);
        clear = 1;
        tick();
        clear = 0;
        chk("clr_busy", 64'(b8.busy), 0);
        chk("clr_product", 64'(b8.product), 0);
        tick(10);
        chk("clr_no_result", 64'(b8.out_valid), 0);
        clear = 1;
        b8.in_valid = 1;
        tick();
        clear = 0;
        b8.in_valid = 0;
        chk("clr_blocks_accept", 64'(b8.busy), 0);
        start8(8'h03, 8'h05);
        tick(8);
        chk("clr_next_valid", 64'(b8.out_valid), 1);
        chk("clr_next_product", 64'(b8.product), 64'h000F);
        b8.out_ready = 1;
        tick();
        b8.out_ready = 0;
        // async reset mid-operation
        start8(8'hFF, 8'hFF);
        tick(3);
        #2 rst = 1;
        #1;
        chk("arst_valid", 64'(b8.out_valid), 0);
        chk("arst_busy", 64'(b8.busy), 0);
        chk("arst_product", 64'(b8.product), 0);
        #3 rst = 0;
        tick();
        chk("arst_in_ready", 64'(b8.in_ready), 1);
        // WIDTH=32 random products with random backpressure
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            b = (n == 0) ? 32'hFFFF_FFFF : $urandom;
            if (n == 0) a = 32'hFFFF_FFFF;
            e = 64'(a) * 64'(b);
            b32.in_a = a;
            b32.in_b = b;
            b32.in_valid = 1;
            tick();
            b32.in_valid = 0;
            b32.in_a = $urandom;
            got = 0;
            for (int t = 0; t < 100 && !got; t++) begin
                if (b32.out_valid) got = 1;
                else tick();
            end
            if (!got) begin
                chk("w32_timeout", 0, 1);
                break;
            end
            tick($urandom_range(0, 3));
            chk("w32_product", b32.product, e);
            b32.out_ready = 1;
            tick();
            b32.out_ready = 0;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
